calc1_alu_scheduler: RTL and testbench
======================================

// Module: calc1_alu_scheduler
// PURPOSE
//  Shares one add/sub/shift ALU between the four calc1 request ports.
//  Each port runs a two-cycle command/operand capture. Pending requests
//  are granted round-robin, and every result goes back on the port that issued it.
//  Sits between the bench driver/ports and the out_data/out_resp bus that calc1_checker compares.
// PARAMETERS
//  RR_START     1   port (1..4) holding priority after reset
//  SHIFT_STALL  1   extra execute cycles for shift commands (0..3)
// PORTS
//  c_clk        in   1    clock, all state changes on posedge
//  reset        in   1    synchronous, active-low; sampled on posedge c_clk
//  req_cmd_in   in   16   port p command at bits [4p-1:4p-4]
//  req_data_in  in   128  port p operand at bits [32p-1:32p-32]
//  out_resp     out  8    port p response at bits [2p-1:2p-2]: 0 none, 1 ok, 2 invalid/overflow
//  out_data     out  128  port p result, same slicing as req_data_in
//  grant_port   out  3    port currently owning the ALU (0 = none), debug only
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - all outputs 0; every port -> P_IDLE; arbiter -> A_IDLE; RR pointer = RR_START
//   - in-flight and pending requests are dropped; they never produce a response
//  Commands: 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right; any other value is invalid
//  Per-port FSM:
//   - P_IDLE: cmd!=0 -> latch cmd and op1 -> P_OP2
//   - P_OP2: latch data as op2; cmd is ignored. Valid cmd -> P_PEND, invalid -> P_INV
//   - P_INV: drive resp=2, data=0 for exactly 1 cycle -> P_IDLE; ALU is not used
//   - P_PEND: wait for grant -> P_WAIT
//   - P_WAIT: leave on the arbiter's A_RESP cycle -> P_IDLE
//   - A cmd arriving on a port that is not in P_IDLE is ignored and gets no response
//  Arbiter FSM:
//   - A_IDLE: if any port is in P_PEND, grant the first pending port at or after the
//     pointer, wrapping 4->1; pointer = grant+1 (wrapping) -> A_EXEC
//   - A_EXEC: compute and register the result. Add/sub -> A_RESP; shift -> A_STALL
//   - A_STALL: stay SHIFT_STALL cycles -> A_RESP; with SHIFT_STALL=0, go A_EXEC -> A_RESP
//   - A_RESP: drive the granted port's resp/data for exactly 1 cycle -> A_IDLE
//  Latency (cmd in cycle T, op2 in T+1):
//   - invalid cmd: response in T+2
//   - add/sub, uncontended: response in T+4
//   - shift, uncontended: response in T+4+SHIFT_STALL
//   - throughput: one ALU op per 3 cycles (add/sub)
//  Arithmetic (32-bit unsigned):
//   - add: carry out of bit 31 -> resp 2, data 0
//   - sub: op1<op2 -> resp 2, data 0
//   - shifts: logical, amount = op2 low 5 bits; shifted-out bits are discarded; resp 1
//  Outputs of a port are 0 in every cycle it is not responding. A port may issue a new
//   cmd the cycle after its response cycle; a cmd in the response cycle itself is ignored.
//  Simultaneous events:
//   - several ports pending -> strict round-robin order from the pointer
//   - P_INV responses and an A_RESP on different ports may coincide; both are driven
// TESTING
//  1 reset; port1 cmd1 op1=0x10 op2=0x22 -> port1 resp=1 data=0x32 in T+4 only; other ports 0
//  2 port2 add 0xFFFFFFFF+0x1 -> resp=2 data=0; port3 sub 5-6 -> resp=2 data=0
//  3 RR_START=1; all four ports add in the same cycle -> responses port1..4 at T+4,T+7,T+10,T+13
//  4 SHIFT_STALL=1; port4 cmd5 op1=0x1 op2=0x21 -> resp=1 data=0x2 at T+5; cmd6 0x80>>3 -> 0x10
//  5 port2 cmd3 -> resp=2 data=0 at T+2; grant_port stays 0; a 2nd cmd on port1 while in P_WAIT gets no response
//  6 reset low while grant_port=3 in A_EXEC -> no port3 response, outputs 0; the next add completes at T+4

Source files
------------

// File: rtl/calc1_alu_scheduler.sv
// calc1_alu_scheduler: four request ports share one add/sub/shift ALU.
// Each port captures a command and two operands over two cycles. A round-robin
// arbiter gives the ALU to one pending port at a time, and the result returns
// on the port that issued it.
module calc1_alu_scheduler #(
  parameter int RR_START    = 1,  // port (1..4) with priority after reset
  parameter int SHIFT_STALL = 1   // extra execute cycles for shifts (0..3)
) (
  input  logic         c_clk,
  input  logic         reset,        // synchronous, active-low
  input  logic [15:0]  req_cmd_in,
  input  logic [127:0] req_data_in,
  output logic [7:0]   out_resp,
  output logic [127:0] out_data,
  output logic [2:0]   grant_port
);

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  // Pointer is kept as a 0-based port index; port number = index + 1.
  localparam logic [1:0] PTR_RESET  = 2'(RR_START - 1);
  localparam logic [1:0] STALL_LAST = (SHIFT_STALL > 0) ? 2'(SHIFT_STALL - 1) : 2'd0;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_OP2  = 3'd1,
    P_PEND = 3'd2,
    P_WAIT = 3'd3,
    P_INV  = 3'd4
  } port_state_e;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_EXEC  = 2'd1,
    A_STALL = 2'd2,
    A_RESP  = 2'd3
  } arb_state_e;

  // Arbiter state
  arb_state_e  arb_q, arb_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  rresp_q, rresp_d;

  // Cross-block views of the per-port captures
  logic [3:0]        pending;
  logic [3:0][3:0]   cmd_all;
  logic [3:0][31:0]  op1_all;
  logic [3:0][31:0]  op2_all;

  // Arbiter decisions consumed by the port FSMs
  logic       grant_fire;
  logic [1:0] sel_idx;
  logic       sel_found;

  function automatic logic cmd_is_valid(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

  // ------------------------------------------------------------------
  // Per-port capture FSMs and response drivers
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      port_state_e pst_q, pst_d;
      logic [3:0]  cmd_q, cmd_d;
      logic [31:0] op1_q, op1_d;
      logic [31:0] op2_q, op2_d;
      logic [3:0]  cmd_in;
      logic [31:0] data_in;
      logic [1:0]  resp_o;
      logic [31:0] data_o;

      assign cmd_in  = req_cmd_in[4*gi +: 4];
      assign data_in = req_data_in[32*gi +: 32];

      // Port state, command and operand registers
      always_ff @(posedge c_clk) begin
        if (!reset) begin
          pst_q <= P_IDLE;
          cmd_q <= '0;
          op1_q <= '0;
          op2_q <= '0;
        end else begin
          pst_q <= pst_d;
          cmd_q <= cmd_d;
          op1_q <= op1_d;
          op2_q <= op2_d;
        end
      end

      // Two-cycle capture, then wait for the ALU or emit an invalid response
      always_comb begin
        pst_d = pst_q;
        cmd_d = cmd_q;
        op1_d = op1_q;
        op2_d = op2_q;
        case (pst_q)
          P_IDLE: begin
            if (cmd_in != CMD_NOP) begin
              cmd_d = cmd_in;
              op1_d = data_in;
              pst_d = P_OP2;
            end
          end
          P_OP2: begin
            op2_d = data_in;
            pst_d = cmd_is_valid(cmd_q) ? P_PEND : P_INV;
          end
          P_INV:  pst_d = P_IDLE;
          P_PEND: begin
            if (grant_fire && (sel_idx == 2'(gi))) pst_d = P_WAIT;
          end
          P_WAIT: begin
            if ((arb_q == A_RESP) && (grant_q == 2'(gi))) pst_d = P_IDLE;
          end
          default: pst_d = P_IDLE;
        endcase
      end

      // Port outputs are zero except in an invalid-response or ALU-response cycle
      always_comb begin
        resp_o = '0;
        data_o = '0;
        if (pst_q == P_INV) begin
          resp_o = RESP_ERR;
        end else if ((arb_q == A_RESP) && (grant_q == 2'(gi))) begin
          resp_o = rresp_q;
          data_o = result_q;
        end
      end

      assign pending[gi]           = (pst_q == P_PEND);
      assign cmd_all[gi]           = cmd_q;
      assign op1_all[gi]           = op1_q;
      assign op2_all[gi]           = op2_q;
      assign out_resp[2*gi +: 2]   = resp_o;
      assign out_data[32*gi +: 32] = data_o;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Round-robin arbiter and shared ALU
  // ------------------------------------------------------------------

  // First pending port at or after the pointer, wrapping 4 -> 1
  always_comb begin
    sel_idx   = ptr_q;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sel_found && pending[ptr_q + 2'(i)]) begin
        sel_idx   = ptr_q + 2'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Arbiter and ALU result registers
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      arb_q       <= A_IDLE;
      grant_q     <= '0;
      ptr_q       <= PTR_RESET;
      stall_cnt_q <= '0;
      result_q    <= '0;
      rresp_q     <= '0;
    end else begin
      arb_q       <= arb_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      stall_cnt_q <= stall_cnt_d;
      result_q    <= result_d;
      rresp_q     <= rresp_d;
    end
  end

  logic [3:0]  alu_cmd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [32:0] alu_sum;

  assign alu_cmd = cmd_all[grant_q];
  assign alu_a   = op1_all[grant_q];
  assign alu_b   = op2_all[grant_q];
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  // Grant, execute, optional shift stall, one response cycle
  always_comb begin
    arb_d       = arb_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    stall_cnt_d = stall_cnt_q;
    result_d    = result_q;
    rresp_d     = rresp_q;
    grant_fire  = 1'b0;
    case (arb_q)
      A_IDLE: begin
        if (sel_found) begin
          grant_fire = 1'b1;
          grant_d    = sel_idx;
          ptr_d      = sel_idx + 2'd1;
          arb_d      = A_EXEC;
        end
      end
      A_EXEC: begin
        arb_d = A_RESP;
        case (alu_cmd)
          CMD_ADD: begin
            if (alu_sum[32]) begin
              result_d = '0;
              rresp_d  = RESP_ERR;
            end else begin
              result_d = alu_sum[31:0];
              rresp_d  = RESP_OK;
            end
          end
          CMD_SUB: begin
            if (alu_a < alu_b) begin
              result_d = '0;
              rresp_d  = RESP_ERR;
            end else begin
              result_d = alu_a - alu_b;
              rresp_d  = RESP_OK;
            end
          end
          CMD_SHL, CMD_SHR: begin
            result_d = (alu_cmd == CMD_SHL) ? (alu_a << alu_b[4:0]) : (alu_a >> alu_b[4:0]);
            rresp_d  = RESP_OK;
            if (SHIFT_STALL > 0) begin
              arb_d       = A_STALL;
              stall_cnt_d = '0;
            end
          end
          default: begin
            // Only valid commands reach the ALU; keep a defined result anyway.
            result_d = '0;
            rresp_d  = RESP_ERR;
          end
        endcase
      end
      A_STALL: begin
        if (stall_cnt_q == STALL_LAST) begin
          arb_d = A_RESP;
        end else begin
          stall_cnt_d = stall_cnt_q + 2'd1;
        end
      end
      A_RESP:  arb_d = A_IDLE;
      default: arb_d = A_IDLE;
    endcase
  end

  assign grant_port = (arb_q == A_IDLE) ? 3'd0 : (3'(grant_q) + 3'd1);

endmodule

// File: tb/tb_calc1_alu_scheduler.sv
// Directed testbench for calc1_alu_scheduler (RR_START=1, SHIFT_STALL=1).
module tb_calc1_alu_scheduler;

  logic         c_clk;
  logic         reset;
  logic [15:0]  req_cmd_in;
  logic [127:0] req_data_in;
  logic [7:0]   out_resp;
  logic [127:0] out_data;
  logic [2:0]   grant_port;

  int tests_run;
  int tests_failed;

  calc1_alu_scheduler #(
    .RR_START    (1),
    .SHIFT_STALL (1)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .grant_port  (grant_port)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int p, input logic [3:0] cmd, input logic [31:0] data);
    req_cmd_in[4*(p-1) +: 4]    = cmd;
    req_data_in[32*(p-1) +: 32] = data;
  endtask

  task automatic clear_inputs();
    req_cmd_in  = '0;
    req_data_in = '0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_resp, input logic [127:0] exp_data);
    check({tag, ".resp"}, 128'(out_resp), 128'(exp_resp));
    check({tag, ".data"}, out_data, exp_data);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    ticks(2);
    reset = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    clear_inputs();

    // ---------- Test 1: reset state, single add on port1 ----------
    do_reset();
    check_out("t1_reset", 8'h00, 128'h0);
    check("t1_reset_grant", 128'(grant_port), 128'd0);
    tick();
    drive(1, 4'd1, 32'h10);                       // cycle T
    tick(); drive(1, 4'd0, 32'h22);               // T+1
    tick(); clear_inputs();                       // T+2
    check_out("t1_T2", 8'h00, 128'h0);
    tick();                                       // T+3
    check_out("t1_T3", 8'h00, 128'h0);
    check("t1_T3_grant", 128'(grant_port), 128'd1);
    tick();                                       // T+4
    check_out("t1_T4", 8'h01, 128'h32);
    tick();                                       // T+5
    check_out("t1_T5", 8'h00, 128'h0);
    ticks(2);

    // ---------- Test 2: add overflow on port2, sub underflow on port3 ----------
    drive(2, 4'd1, 32'hFFFF_FFFF);
    drive(3, 4'd2, 32'd5);                        // T
    tick(); drive(2, 4'd0, 32'h1); drive(3, 4'd0, 32'd6);
    tick(); clear_inputs();                       // T+2
    tick();                                       // T+3
    check("t2_T3_grant", 128'(grant_port), 128'd2);
    tick();                                       // T+4
    check_out("t2_T4_port2_ovf", 8'h08, 128'h0);
    ticks(3);                                     // T+7
    check_out("t2_T7_port3_undf", 8'h20, 128'h0);
    ticks(3);

    // ---------- Test 3: four simultaneous adds, round-robin from port1 ----------
    do_reset();
    tick();
    for (int p = 1; p <= 4; p++) drive(p, 4'd1, 32'(p));
    tick();
    for (int p = 1; p <= 4; p++) drive(p, 4'd0, 32'h100 * p);
    tick(); clear_inputs();                       // T+2
    ticks(2);                                     // T+4
    check_out("t3_T4_port1", 8'h01, {96'h0, 32'h101});
    tick();                                       // T+5
    check_out("t3_T5_quiet", 8'h00, 128'h0);
    ticks(2);                                     // T+7
    check_out("t3_T7_port2", 8'h04, {64'h0, 32'h202, 32'h0});
    ticks(3);                                     // T+10
    check_out("t3_T10_port3", 8'h10, {32'h0, 32'h303, 64'h0});
    ticks(3);                                     // T+13
    check_out("t3_T13_port4", 8'h40, {32'h404, 96'h0});
    ticks(2);

    // ---------- Test 4: shifts on port4 with one stall cycle ----------
    drive(4, 4'd5, 32'h1);                        // T
    tick(); drive(4, 4'd0, 32'h21);
    tick(); clear_inputs();                       // T+2
    ticks(2);                                     // T+4
    check_out("t4_shl_T4", 8'h00, 128'h0);
    check("t4_shl_T4_grant", 128'(grant_port), 128'd4);
    tick();                                       // T+5
    check_out("t4_shl_T5", 8'h40, {32'h2, 96'h0});
    tick();                                       // T+6: port idle again, issue next cmd
    drive(4, 4'd6, 32'h80);                       // T'
    tick(); drive(4, 4'd0, 32'h3);
    tick(); clear_inputs();
    ticks(3);                                     // T'+5
    check_out("t4_shr_T5", 8'h40, {32'h10, 96'h0});
    ticks(2);

    // ---------- Test 5: invalid cmd on port2; cmd on port1 in P_WAIT ignored ----------
    drive(2, 4'd3, 32'h1234);                     // T
    tick(); drive(2, 4'd0, 32'h5678);
    check("t5_T1_grant", 128'(grant_port), 128'd0);
    tick(); clear_inputs();                       // T+2
    check_out("t5_T2_invalid", 8'h08, 128'h0);
    check("t5_T2_grant", 128'(grant_port), 128'd0);
    tick();                                       // T+3
    check_out("t5_T3_quiet", 8'h00, 128'h0);
    check("t5_T3_grant", 128'(grant_port), 128'd0);
    ticks(2);
    drive(1, 4'd1, 32'h1);                        // U
    tick(); drive(1, 4'd0, 32'h1);
    tick(); clear_inputs();                       // U+2
    tick();                                       // U+3: port1 in P_WAIT
    drive(1, 4'd1, 32'h7);
    tick(); clear_inputs();                       // U+4 response
    check_out("t5_U4_port1", 8'h01, 128'h2);
    for (int k = 5; k <= 10; k++) begin
      tick();
      check_out($sformatf("t5_U%0d_no_extra", k), 8'h00, 128'h0);
    end

    // ---------- Test 6: reset during A_EXEC for port3 ----------
    drive(3, 4'd1, 32'h3);                        // T
    tick(); drive(3, 4'd0, 32'h4);
    tick(); clear_inputs();                       // T+2
    tick();                                       // T+3: A_EXEC
    check("t6_T3_grant", 128'(grant_port), 128'd3);
    reset = 1'b0;
    tick();                                       // T+4 after reset edge
    check_out("t6_T4_after_reset", 8'h00, 128'h0);
    check("t6_T4_grant", 128'(grant_port), 128'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("t6_dropped_%0d", k), 8'h00, 128'h0);
    end
    drive(3, 4'd1, 32'h3);                        // new T
    tick(); drive(3, 4'd0, 32'h4);
    tick(); clear_inputs();
    tick();                                       // T+3
    check_out("t6_new_T3", 8'h00, 128'h0);
    tick();                                       // T+4
    check_out("t6_new_T4", 8'h10, {32'h0, 32'h7, 64'h0});
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
